// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding and load-use hazard controller.
// Slot records carry a fixed-width rd so any REG_ADDR_W up to SLOT_RD_W fits.
package fwd_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int SLOT_RD_W  = 8;

    typedef logic [SLOT_RD_W-1:0] slot_rd_t;

    localparam slot_rd_t ZERO_REG = '0;

    typedef struct packed {
        logic     valid;
        slot_rd_t rd;
        logic     reg_write;
        logic     mem_read;
    } slot_rec_t;

    typedef struct packed {
        logic alu_alu_s;
        logic bypass_alu;
        logic dmem_alu;
    } fwd_sel_t;

    localparam slot_rec_t BUBBLE = '0;

    // A slot supplies src when it is a live writer of that register; r0 is excluded when hardwired.
    function automatic logic writer_matches(input slot_rec_t w, input slot_rd_t src,
                                            input logic zero_hardwired);
        return w.valid & w.reg_write & (w.rd == src) & ~(zero_hardwired & (src == ZERO_REG));
    endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Forwarding select for one ALU operand: youngest live writer wins, loads in EX
// cannot forward and are reported as a load hit instead.
module fwd_operand_sel
    import fwd_pkg::*;
#(
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  slot_rd_t  src_i,
    input  logic      use_i,
    input  slot_rec_t ex_i,
    input  slot_rec_t d2_i,
    output fwd_sel_t  sel_o,
    output logic      load_hit_o
);

    logic ex_hit;
    logic d2_hit;

    assign ex_hit     = use_i & writer_matches(ex_i, src_i, ZERO_REG_HARDWIRED);
    assign d2_hit     = use_i & writer_matches(d2_i, src_i, ZERO_REG_HARDWIRED);
    assign load_hit_o = ex_hit & ex_i.mem_read;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_o = '0;
        if (ex_hit && !ex_i.mem_read) begin
            sel_o.alu_alu_s = 1'b1;
        end else if (d2_hit && d2_i.mem_read) begin
            sel_o.dmem_alu = 1'b1;
        end else if (d2_hit) begin
            sel_o.bypass_alu = 1'b1;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ID/EX forwarding-select and load-use stall controller. Selects are registered so
// they line up with the instruction while it occupies EX; stall is combinational.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W         = fwd_pkg::REG_ADDR_W,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic                  alu_alu_s1,
    output logic                  bypass_alu1,
    output logic                  dmem_alu1,
    output logic                  alu_alu_s2,
    output logic                  bypass_alu2,
    output logic                  dmem_alu2
);

    slot_rec_t ex_q, ex_d;
    slot_rec_t d2_q, d2_d;
    slot_rec_t id_rec;
    fwd_sel_t  sel1_q, sel1_d, sel1_c;
    fwd_sel_t  sel2_q, sel2_d, sel2_c;
    logic      load_hit1, load_hit2;

    assign id_rec = '{valid:     id_valid,
                      rd:        slot_rd_t'(id_rd),
                      reg_write: id_reg_write,
                      mem_read:  id_mem_read};

    fwd_operand_sel #(.ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_op1 (
        .src_i      (slot_rd_t'(id_rs1)),
        .use_i      (id_use_rs1 & id_valid),
        .ex_i       (ex_q),
        .d2_i       (d2_q),
        .sel_o      (sel1_c),
        .load_hit_o (load_hit1)
    );

    fwd_operand_sel #(.ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_op2 (
        .src_i      (slot_rd_t'(id_rs2)),
        .use_i      (id_use_rs2 & id_valid),
        .ex_i       (ex_q),
        .d2_i       (d2_q),
        .sel_o      (sel2_c),
        .load_hit_o (load_hit2)
    );

    assign stall = id_valid & ~flush & (load_hit1 | load_hit2);

    always_comb begin
        ex_d   = id_rec;
        d2_d   = ex_q;
        sel1_d = sel1_c;
        sel2_d = sel2_c;
        if (flush) begin
            // The EX instruction is killed too, so it must not reach d2 and forward later.
            ex_d   = BUBBLE;
            d2_d   = BUBBLE;
            sel1_d = '0;
            sel2_d = '0;
        end else if (stall) begin
            ex_d   = BUBBLE;
            sel1_d = '0;
            sel2_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q   <= BUBBLE;
            d2_q   <= BUBBLE;
            sel1_q <= '0;
            sel2_q <= '0;
        end else begin
            ex_q   <= ex_d;
            d2_q   <= d2_d;
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
        end
    end

    assign alu_alu_s1  = sel1_q.alu_alu_s;
    assign bypass_alu1 = sel1_q.bypass_alu;
    assign dmem_alu1   = sel1_q.dmem_alu;
    assign alu_alu_s2  = sel2_q.alu_alu_s;
    assign bypass_alu2 = sel2_q.bypass_alu;
    assign dmem_alu2   = sel2_q.dmem_alu;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: instruction sequences with hand-computed
// select vectors {alu_alu_s1,bypass_alu1,dmem_alu1,alu_alu_s2,bypass_alu2,dmem_alu2}.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic       flush;
    logic       stall;
    logic       alu_alu_s1, bypass_alu1, dmem_alu1;
    logic       alu_alu_s2, bypass_alu2, dmem_alu2;

    int checks   = 0;
    int failures = 0;

    logic [5:0] sel_v;
    assign sel_v = {alu_alu_s1, bypass_alu1, dmem_alu1, alu_alu_s2, bypass_alu2, dmem_alu2};

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .ZERO_REG_HARDWIRED(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .alu_alu_s1   (alu_alu_s1),
        .bypass_alu1  (bypass_alu1),
        .dmem_alu1    (dmem_alu1),
        .alu_alu_s2   (alu_alu_s2),
        .bypass_alu2  (bypass_alu2),
        .dmem_alu2    (dmem_alu2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_sel(input string tag, input logic [5:0] exp);
        check(tag, sel_v, exp);
    endtask

    task automatic check_stall(input string tag, input logic exp);
        #1;
        check(tag, {5'b0, stall}, {5'b0, exp});
    endtask

    task automatic issue(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_use_rs1   = u1;
        id_rs2       = rs2;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        check_sel("reset_sel", 6'b000_000);
        check_stall("reset_stall", 1'b0);
        reset = 1'b0;

        // ADD r3 then SUB reading r3 on rs1
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        check_stall("add_r3_stall", 1'b0);
        tick();
        issue(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        check_stall("sub_r3_stall", 1'b0);
        tick();
        check_sel("ex_fwd_rs1", 6'b100_000);

        // ADD r4, NOP, AND reading r4 on rs2
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        check_sel("no_dep_sel", 6'b000_000);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        issue(1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        check_sel("d2_bypass_rs2", 6'b000_010);

        // LW r5 then ADD r6 = r5 + r5: one bubble, then DOut forward on both operands
        issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        check_stall("load_use_stall", 1'b1);
        tick();
        check_sel("stall_bubble_sel", 6'b000_000);
        check_stall("stall_one_cycle", 1'b0);
        tick();
        check_sel("dmem_both", 6'b001_001);

        // ADD r7, ADD r7, OR reading r7: youngest writer wins
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0);
        tick();
        check_sel("youngest_wins", 6'b100_000);

        // Register written in EX read on both operands
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd14, 1'b1, 5'd14, 1'b1, 5'd15, 1'b1, 1'b0);
        tick();
        check_sel("ex_fwd_both", 6'b100_100);

        // Writers to r0 (ALU then load) never forward or stall
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd16, 1'b1, 1'b0);
        check_stall("r0_load_no_stall", 1'b0);
        tick();
        check_sel("r0_no_fwd", 6'b000_000);

        // LW r8 in EX, reader of r8 in ID, flush in the same cycle
        issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd12, 1'b1, 1'b1);
        flush = 1'b1;
        check_stall("flush_beats_stall", 1'b0);
        tick();
        flush = 1'b0;
        check_sel("flush_sel", 6'b000_000);
        issue(1'b1, 5'd8, 1'b1, 5'd12, 1'b1, 5'd17, 1'b1, 1'b0);
        check_stall("flush_ex_bubble", 1'b0);
        tick();
        check_sel("flush_d2_bubble", 6'b000_000);

        // Async reset in the middle of a load-use stall
        issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd18, 1'b1, 1'b0);
        check_stall("pre_reset_stall", 1'b1);
        #1;
        reset = 1'b1;
        check_stall("reset_kills_stall", 1'b0);
        check_sel("reset_async_sel", 6'b000_000);
        tick();
        reset = 1'b0;
        check_sel("reset_held_sel", 6'b000_000);
        check_stall("post_reset_reader", 1'b0);
        tick();
        check_sel("post_reset_no_residual", 6'b000_000);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check_sel("idle_after_reset", 6'b000_000);

        // Recovery: ordinary EX forward on operand 2
        issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd19, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd1, 1'b1, 5'd19, 1'b1, 5'd20, 1'b1, 1'b0);
        tick();
        check_sel("recover_fwd_rs2", 6'b000_100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
